// File: rtl/sysctl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sysctl_pkg
// Description : Shared types and IPROG command-stream constants for the
//               system-controller reboot sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
package sysctl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_GAP   = 2'd2,
        ST_DONE  = 2'd3
    } reboot_state_t;

    localparam int IPROG_LEN = 10;
    localparam int IDX_W     = 4;
    localparam logic [IDX_W-1:0] C_IDX_LAST = IDX_W'(IPROG_LEN - 1);

    localparam logic [15:0] C_IPROG_DUMMY      = 16'hFFFF;
    localparam logic [15:0] C_IPROG_SYNC_HI    = 16'hAA99;
    localparam logic [15:0] C_IPROG_SYNC_LO    = 16'h5566;
    localparam logic [15:0] C_IPROG_GEN1_HDR   = 16'h3261;
    localparam logic [15:0] C_IPROG_GEN2_HDR   = 16'h3281;
    localparam logic [7:0]  C_IPROG_GEN2_OPC   = 8'h0B;
    localparam logic [15:0] C_IPROG_CMD_HDR    = 16'h30A1;
    localparam logic [15:0] C_IPROG_CMD        = 16'h000E;
    localparam logic [15:0] C_IPROG_NOOP       = 16'h2000;

    // Word idx of the IPROG stream; words 4 and 6 carry the multiboot address.
    function automatic logic [15:0] iprog_word(input logic [IDX_W-1:0] idx,
                                               input logic [23:0]      addr);
        logic [15:0] w_word;
        w_word = C_IPROG_NOOP;
        case (idx)
            4'd0:    w_word = C_IPROG_DUMMY;
            4'd1:    w_word = C_IPROG_SYNC_HI;
            4'd2:    w_word = C_IPROG_SYNC_LO;
            4'd3:    w_word = C_IPROG_GEN1_HDR;
            4'd4:    w_word = addr[15:0];
            4'd5:    w_word = C_IPROG_GEN2_HDR;
            4'd6:    w_word = {C_IPROG_GEN2_OPC, addr[23:16]};
            4'd7:    w_word = C_IPROG_CMD_HDR;
            4'd8:    w_word = C_IPROG_CMD;
            default: w_word = C_IPROG_NOOP;
        endcase
        return w_word;
    endfunction

endpackage
`default_nettype wire

// File: rtl/sysctl_reboot_wdt.sv
`default_nettype none
// ============================================================================
// Module      : sysctl_reboot_wdt
// Description : Saturating DONE-state watchdog; raises a sticky fallback reset
//               once DONE has lasted WATCHDOG_CYCLES cycles.
//               Only built with SYSCTL_REBOOT_WATCHDOG_EN defined.
// Revision    : 1.0 - initial release
// ============================================================================
`ifdef SYSCTL_REBOOT_WATCHDOG_EN
module sysctl_reboot_wdt #(
    parameter logic [31:0] WATCHDOG_CYCLES = 32'd100000000
) (
    input  logic clk,
    input  logic rst,
    input  logic i_done_enter,
    input  logic i_in_done,
    output logic o_fallback_reset
);

    localparam logic [31:0] C_CNT_MAX = 32'hFFFF_FFFF;

    logic [31:0] r_cnt;
    logic        r_fallback;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt      <= 32'd0;
            r_fallback <= 1'b0;
        end else begin
            if (i_done_enter) begin
                r_cnt <= 32'd0;
            end else if (i_in_done && (r_cnt != C_CNT_MAX)) begin
                r_cnt <= r_cnt + 32'd1;
            end
            if (i_in_done && (r_cnt == (WATCHDOG_CYCLES - 32'd1))) begin
                r_fallback <= 1'b1;
            end
        end
    end

    assign o_fallback_reset = r_fallback;

endmodule
`endif
`default_nettype wire

// File: rtl/sysctl_reboot_seq.sv
`default_nettype none
// ============================================================================
// Module      : sysctl_reboot_seq
// Description : Arbitrates the ICAP driver between CSR word writes and a
//               hardware IPROG reboot sequence; locks software out afterwards.
//               Optional watchdog fallback: SYSCTL_REBOOT_WATCHDOG_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module sysctl_reboot_seq
    import sysctl_pkg::*;
#(
    parameter logic [31:0] watchdog_cycles = 32'd100000000
) (
    input  logic        sys_clk,
    input  logic        sys_rst,
    input  logic        csr_we,
    input  logic [15:0] csr_d,
    input  logic        csr_ce,
    input  logic        csr_write,
    output logic        csr_ready,
    input  logic        reboot_req,
    input  logic [23:0] reboot_addr,
    input  logic        icap_ready,
    output logic        icap_we,
    output logic [15:0] icap_d,
    output logic        icap_ce,
    output logic        icap_write,
    output logic        busy,
    output logic        dropped,
    output logic        fallback_reset
);

    reboot_state_t    r_state;
    reboot_state_t    w_state_nxt;
    logic [IDX_W-1:0] r_idx;
    logic [23:0]      r_addr;
    logic             r_busy;
    logic             r_sw_we;
    logic             r_dropped;
    logic [15:0]      r_icap_d;
    logic             r_icap_ce;
    logic             r_icap_write;

    logic             w_csr_ready;
    logic             w_start;
    logic             w_sw_accept;
    logic             w_issue;
    logic [15:0]      w_word;

    assign w_csr_ready = (r_state == ST_IDLE) & icap_ready & ~reboot_req & ~sys_rst;
    assign w_start     = (r_state == ST_IDLE) & reboot_req;
    assign w_sw_accept = csr_we & w_csr_ready;
    assign w_issue     = (r_state == ST_ISSUE) & icap_ready;
    assign w_word      = iprog_word(r_idx, r_addr);

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // r_busy distinguishes a reboot-word GAP from a software-word GAP.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (reboot_req) begin
                    w_state_nxt = ST_ISSUE;
                end else if (w_sw_accept) begin
                    w_state_nxt = ST_GAP;
                end
            end
            ST_ISSUE: begin
                if (icap_ready) begin
                    w_state_nxt = ST_GAP;
                end
            end
            ST_GAP: begin
                if (!r_busy) begin
                    w_state_nxt = ST_IDLE;
                end else if (r_idx == C_IDX_LAST) begin
                    w_state_nxt = ST_DONE;
                end else begin
                    w_state_nxt = ST_ISSUE;
                end
            end
            ST_DONE:  w_state_nxt = ST_DONE;
            default:  w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            r_idx        <= '0;
            r_addr       <= 24'd0;
            r_busy       <= 1'b0;
            r_sw_we      <= 1'b0;
            r_dropped    <= 1'b0;
            r_icap_d     <= 16'd0;
            r_icap_ce    <= 1'b1;
            r_icap_write <= 1'b1;
        end else begin
            r_sw_we   <= w_sw_accept;
            r_dropped <= csr_we & ~w_csr_ready;
            if (w_start) begin
                r_busy <= 1'b1;
                r_idx  <= '0;
                r_addr <= reboot_addr;
            end
            if (w_sw_accept) begin
                r_icap_d     <= csr_d;
                r_icap_ce    <= csr_ce;
                r_icap_write <= csr_write;
            end
            // Hold the last reboot word on the bus once its strobe is gone.
            if (w_issue) begin
                r_icap_d     <= w_word;
                r_icap_ce    <= 1'b0;
                r_icap_write <= 1'b0;
            end
            if ((r_state == ST_GAP) && r_busy && (r_idx != C_IDX_LAST)) begin
                r_idx <= r_idx + 1'b1;
            end
        end
    end

    // Reboot words are strobed combinationally so ISSUE costs no extra cycle.
    assign icap_we    = r_sw_we | w_issue;
    assign icap_d     = w_issue ? w_word : r_icap_d;
    assign icap_ce    = w_issue ? 1'b0   : r_icap_ce;
    assign icap_write = w_issue ? 1'b0   : r_icap_write;
    assign csr_ready  = w_csr_ready;
    assign busy       = r_busy;
    assign dropped    = r_dropped;

`ifdef SYSCTL_REBOOT_WATCHDOG_EN
    logic w_done_enter;
    logic w_in_done;

    assign w_done_enter = (w_state_nxt == ST_DONE) && (r_state != ST_DONE);
    assign w_in_done    = (r_state == ST_DONE);

    sysctl_reboot_wdt #(
        .WATCHDOG_CYCLES (watchdog_cycles)
    ) u_wdt (
        .clk              (sys_clk),
        .rst              (sys_rst),
        .i_done_enter     (w_done_enter),
        .i_in_done        (w_in_done),
        .o_fallback_reset (fallback_reset)
    );
`else
    logic w_unused_cfg;
    assign w_unused_cfg   = ^watchdog_cycles;
    assign fallback_reset = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_sysctl_reboot_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_sysctl_reboot_seq
// Description : Randomized self-checking bench for sysctl_reboot_seq against a
//               cycle-rule reference model of the IPROG issue schedule.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sysctl_reboot_seq;

    logic        sys_clk = 1'b0;
    logic        sys_rst;
    logic        csr_we;
    logic [15:0] csr_d;
    logic        csr_ce;
    logic        csr_write;
    logic        csr_ready;
    logic        reboot_req;
    logic [23:0] reboot_addr;
    logic        icap_ready;
    logic        icap_we;
    logic [15:0] icap_d;
    logic        icap_ce;
    logic        icap_write;
    logic        busy;
    logic        dropped;
    logic        fallback_reset;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 sys_clk = ~sys_clk;

    sysctl_reboot_seq #(
        .watchdog_cycles (32'd8)
    ) dut (
        .sys_clk        (sys_clk),
        .sys_rst        (sys_rst),
        .csr_we         (csr_we),
        .csr_d          (csr_d),
        .csr_ce         (csr_ce),
        .csr_write      (csr_write),
        .csr_ready      (csr_ready),
        .reboot_req     (reboot_req),
        .reboot_addr    (reboot_addr),
        .icap_ready     (icap_ready),
        .icap_we        (icap_we),
        .icap_d         (icap_d),
        .icap_ce        (icap_ce),
        .icap_write     (icap_write),
        .busy           (busy),
        .dropped        (dropped),
        .fallback_reset (fallback_reset)
    );

    function automatic logic [15:0] model_word(input int i, input logic [23:0] a);
        logic [15:0] tbl [10];
        tbl = '{16'hFFFF, 16'hAA99, 16'h5566, 16'h3261, a[15:0],
                16'h3281, {8'h0B, a[23:16]}, 16'h30A1, 16'h000E, 16'h2000};
        return tbl[i];
    endfunction

    task automatic step();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic idle_inputs();
        csr_we      = 1'b0;
        csr_d       = 16'd0;
        csr_ce      = 1'b1;
        csr_write   = 1'b1;
        reboot_req  = 1'b0;
        reboot_addr = 24'd0;
        icap_ready  = 1'b1;
    endtask

    task automatic do_reset();
        idle_inputs();
        sys_rst = 1'b1;
        step();
        step();
        sys_rst = 1'b0;
    endtask

    task automatic test_reset();
        idle_inputs();
        sys_rst = 1'b1;
        csr_we  = 1'b1;
        step();
        #1;
        n_cmp++; if (icap_we !== 1'b0)        begin n_bad++; $display("FAIL reset_icap_we got %b want 0", icap_we); end
        n_cmp++; if (icap_d !== 16'h0000)     begin n_bad++; $display("FAIL reset_icap_d got %h want 0000", icap_d); end
        n_cmp++; if (icap_ce !== 1'b1)        begin n_bad++; $display("FAIL reset_icap_ce got %b want 1", icap_ce); end
        n_cmp++; if (icap_write !== 1'b1)     begin n_bad++; $display("FAIL reset_icap_write got %b want 1", icap_write); end
        n_cmp++; if (busy !== 1'b0)           begin n_bad++; $display("FAIL reset_busy got %b want 0", busy); end
        n_cmp++; if (dropped !== 1'b0)        begin n_bad++; $display("FAIL reset_dropped got %b want 0", dropped); end
        n_cmp++; if (fallback_reset !== 1'b0) begin n_bad++; $display("FAIL reset_fallback got %b want 0", fallback_reset); end
        n_cmp++; if (csr_ready !== 1'b0)      begin n_bad++; $display("FAIL reset_csr_ready got %b want 0", csr_ready); end
        csr_we  = 1'b0;
        sys_rst = 1'b0;
        step();
    endtask

    task automatic test_sw_write();
        logic [15:0] d, last_d;
        logic        ce, wr, rdy, last_ce, last_wr;
        do_reset();
        last_d = 16'h0000; last_ce = 1'b1; last_wr = 1'b1;
        for (int i = 0; i < 12; i++) begin
            d   = (i == 0) ? 16'h1234 : 16'($urandom);
            ce  = (i == 0) ? 1'b0 : 1'($urandom);
            wr  = (i == 0) ? 1'b1 : 1'($urandom);
            rdy = (i == 0) ? 1'b1 : ($urandom_range(0, 3) != 0);
            csr_we = 1'b1; csr_d = d; csr_ce = ce; csr_write = wr; icap_ready = rdy;
            #1;
            n_cmp++; if (csr_ready !== rdy) begin n_bad++; $display("FAIL sw_ready_n i=%0d got %b want %b", i, csr_ready, rdy); end
            step();
            csr_we = 1'b0; icap_ready = 1'b1;
            if (rdy) begin last_d = d; last_ce = ce; last_wr = wr; end
            #1;
            n_cmp++; if (icap_we !== rdy)     begin n_bad++; $display("FAIL sw_we i=%0d got %b want %b", i, icap_we, rdy); end
            n_cmp++; if (dropped !== !rdy)    begin n_bad++; $display("FAIL sw_dropped i=%0d got %b want %b", i, dropped, !rdy); end
            n_cmp++; if ({icap_d, icap_ce, icap_write} !== {last_d, last_ce, last_wr})
                begin n_bad++; $display("FAIL sw_data i=%0d got %h/%b/%b want %h/%b/%b", i, icap_d, icap_ce, icap_write, last_d, last_ce, last_wr); end
            n_cmp++; if (csr_ready !== !rdy)  begin n_bad++; $display("FAIL sw_ready_n1 i=%0d got %b want %b", i, csr_ready, !rdy); end
            step();
            #1;
            n_cmp++; if ({icap_we, dropped, csr_ready} !== 3'b001)
                begin n_bad++; $display("FAIL sw_n2 i=%0d got we/drop/rdy %b%b%b want 001", i, icap_we, dropped, csr_ready); end
            n_cmp++; if (busy !== 1'b0)       begin n_bad++; $display("FAIL sw_busy i=%0d got %b want 0", i, busy); end
            step();
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        csr_we = 1'b1; csr_d = 16'hBEEF; csr_ce = 1'b0; csr_write = 1'b0;
        step();
        csr_d = 16'hDEAD;
        #1;
        n_cmp++; if ({icap_we, icap_d} !== {1'b1, 16'hBEEF}) begin n_bad++; $display("FAIL b2b_first got %b/%h want 1/beef", icap_we, icap_d); end
        n_cmp++; if (csr_ready !== 1'b0) begin n_bad++; $display("FAIL b2b_gap_ready got %b want 0", csr_ready); end
        step();
        csr_we = 1'b0;
        #1;
        n_cmp++; if ({icap_we, dropped} !== 2'b01) begin n_bad++; $display("FAIL b2b_second got we/drop %b%b want 01", icap_we, dropped); end
        n_cmp++; if (icap_d !== 16'hBEEF) begin n_bad++; $display("FAIL b2b_hold got %h want beef", icap_d); end
        step();
    endtask

    // Reference rule: word n strobes on the first ready cycle at least two
    // cycles after the previous strobe (cycle 1 for the first word); DONE
    // begins two cycles after the last strobe.
    task automatic run_reboot(input logic [23:0] addr, input int stall_pct,
                              input int stall_word, input bit collide, input bit noise);
        int n, earliest, done_cyc, cyc;
        bit prev_we, exp_we, exp_fb;
        n = 0; earliest = 1; done_cyc = -1; prev_we = collide;
        reboot_req = 1'b1; reboot_addr = addr; csr_we = collide;
        csr_d = 16'($urandom); icap_ready = 1'b1;
        #1;
        n_cmp++; if (csr_ready !== 1'b0) begin n_bad++; $display("FAIL rb_ready_c0 got %b want 0", csr_ready); end
        step();
        for (cyc = 1; cyc < 400; cyc++) begin
            reboot_req  = noise && ($urandom_range(0, 5) == 0);
            reboot_addr = 24'($urandom);
            csr_we      = noise && ($urandom_range(0, 3) == 0);
            csr_d       = 16'($urandom);
            icap_ready  = ($urandom_range(0, 99) >= stall_pct);
            if (n == stall_word && cyc >= earliest && cyc < earliest + 5) icap_ready = 1'b0;
            exp_we = icap_ready && (n < 10) && (cyc >= earliest);
`ifdef SYSCTL_REBOOT_WATCHDOG_EN
            exp_fb = (done_cyc >= 0) && (cyc >= done_cyc + 8);
`else
            exp_fb = 1'b0;
`endif
            #1;
            n_cmp++; if (icap_we !== exp_we) begin n_bad++; $display("FAIL rb_we cyc=%0d n=%0d got %b want %b", cyc, n, icap_we, exp_we); end
            n_cmp++; if ({busy, csr_ready} !== 2'b10) begin n_bad++; $display("FAIL rb_busy_ready cyc=%0d got %b%b want 10", cyc, busy, csr_ready); end
            n_cmp++; if (dropped !== prev_we) begin n_bad++; $display("FAIL rb_dropped cyc=%0d got %b want %b", cyc, dropped, prev_we); end
            n_cmp++; if (fallback_reset !== exp_fb) begin n_bad++; $display("FAIL rb_fallback cyc=%0d done=%0d got %b want %b", cyc, done_cyc, fallback_reset, exp_fb); end
            if (exp_we) begin
                n_cmp++;
                if ({icap_d, icap_ce, icap_write} !== {model_word(n, addr), 2'b00}) begin
                    n_bad++;
                    $display("FAIL rb_word n=%0d got %h/%b/%b want %h/0/0", n, icap_d, icap_ce, icap_write, model_word(n, addr));
                end
                n++;
                earliest = cyc + 2;
                if (n == 10) done_cyc = cyc + 2;
            end
            prev_we = csr_we;
            if (done_cyc >= 0 && cyc >= done_cyc + 12) break;
            step();
        end
        n_cmp++; if (n != 10) begin n_bad++; $display("FAIL rb_timeout words got %0d want 10", n); end
        step();
        idle_inputs();
    endtask

    task automatic test_reboot_basic();
        do_reset();
        run_reboot(24'h0A0000, 0, -1, 1'b0, 1'b0);
    endtask

    task automatic test_ready_stall();
        do_reset();
        run_reboot(24'($urandom), 0, 4, 1'b0, 1'b0);
        do_reset();
        run_reboot(24'($urandom), 35, -1, 1'b0, 1'b1);
    endtask

    task automatic test_collision();
        do_reset();
        run_reboot(24'($urandom), 20, -1, 1'b1, 1'b1);
    endtask

    task automatic test_reset_mid();
        logic [23:0] a;
        do_reset();
        a = 24'($urandom);
        reboot_req = 1'b1; reboot_addr = a; icap_ready = 1'b1;
        step();
        reboot_req = 1'b0;
        repeat (12) step();
        #1;
        n_cmp++; if ({icap_we, icap_d} !== {1'b1, model_word(6, a)})
            begin n_bad++; $display("FAIL mid_word6 got %b/%h want 1/%h", icap_we, icap_d, model_word(6, a)); end
        sys_rst = 1'b1;
        #1;
        n_cmp++; if ({icap_we, icap_d, icap_ce, icap_write} !== {1'b0, 16'h0000, 2'b11})
            begin n_bad++; $display("FAIL mid_async_icap got %b/%h/%b/%b want 0/0000/1/1", icap_we, icap_d, icap_ce, icap_write); end
        n_cmp++; if ({busy, dropped, fallback_reset, csr_ready} !== 4'b0000)
            begin n_bad++; $display("FAIL mid_async_status got %b%b%b%b want 0000", busy, dropped, fallback_reset, csr_ready); end
        step();
        sys_rst = 1'b0;
        step();
        run_reboot(24'($urandom), 10, -1, 1'b0, 1'b0);
    endtask

    initial begin
        sys_rst = 1'b1;
        idle_inputs();
        test_reset();
        test_sw_write();
        test_back_to_back();
        test_reboot_basic();
        test_ready_stall();
        test_collision();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/sysctl_reboot_seq.md
# sysctl_reboot_seq

Reconfiguration controller placed between the system controller's CSR ICAP path and the ICAP driver. It arbitrates the ICAP driver between software word writes and a hardware reboot request, and it sequences the fixed multiboot (IPROG) command stream into the driver using the driver's ready handshake. After IPROG it locks out software writes, and it can optionally fall back to a hard reset if reconfiguration never happens.

## Interface
Parameters:
- `watchdog_cycles`, default 32'd100000000: cycles spent in DONE before the fallback reset fires (only with the watchdog macro).

Ports:
- `sys_clk`  in  1  system clock.
- `sys_rst`  in  1  reset, asynchronous and active-high.
- `csr_we`  in  1  one-cycle software ICAP word write strobe.
- `csr_d`  in  16  software ICAP data.
- `csr_ce`  in  1  software ICAP CE value, passed through unchanged.
- `csr_write`  in  1  software ICAP WRITE value, passed through unchanged.
- `csr_ready`  out  1  a software write will be accepted this cycle.
- `reboot_req`  in  1  one-cycle request to start the IPROG sequence.
- `reboot_addr`  in  24  multiboot bitstream address, sampled on `reboot_req`.
- `icap_ready`  in  1  driver can accept a word.
- `icap_we`  out  1  one-cycle word strobe to the driver.
- `icap_d`  out  16  word to the driver.
- `icap_ce`  out  1  CE to the driver.
- `icap_write`  out  1  WRITE to the driver.
- `busy`  out  1  reboot sequence is active or finished.
- `dropped`  out  1  one-cycle pulse when a software write was discarded.
- `fallback_reset`  out  1  sticky fallback reset request.

## Operation
- States: IDLE, ISSUE, GAP, DONE.
- IDLE:
  - Software writes pass through. `csr_ready = icap_ready & ~reboot_req`.
  - If `csr_we & csr_ready`: register `csr_d`, `csr_ce` and `csr_write` onto the `icap_*` outputs and pulse `icap_we` on the next cycle. The state then becomes GAP for one cycle.
  - If `csr_we & ~csr_ready`: pulse `dropped` on the next cycle. No write is issued.
- `reboot_req` in IDLE:
  - Latch `reboot_addr` and clear the word index (idx) to 0.
  - Go to ISSUE and set `busy`.
  - A simultaneous `csr_we` is dropped: `dropped` pulses.
- ISSUE:
  - When `icap_ready` is 1, pulse `icap_we` with `icap_d = word[idx]`, `icap_ce = 0`, `icap_write = 0`, then go to GAP.
  - Otherwise stay in ISSUE.
- GAP: always lasts one cycle, so `icap_we` is never asserted on two consecutive cycles.
  - From a reboot word: if idx = 9, go to DONE; otherwise increment idx and go to ISSUE.
  - From a software word: go to IDLE.
- Word sequence, idx 0..9: FFFF, AA99, 5566, 3261, addr[15:0], 3281, {8'h0B, addr[23:16]}, 30A1, 000E, 2000.
- DONE: terminal state. `busy = 1`, `csr_ready = 0`, and every `csr_we` pulses `dropped`. Only `sys_rst` leaves DONE.
- A `reboot_req` that arrives in ISSUE, GAP or DONE is ignored and is not queued.
- Software writes arriving in ISSUE or GAP are dropped and pulse `dropped`.

## Timing
- Reset values: `icap_we` 0, `icap_d` 0, `icap_ce` 1, `icap_write` 1, `busy` 0, `dropped` 0, `fallback_reset` 0, `csr_ready` 0 while `sys_rst` is high. The state is IDLE and idx is 0.
- Software write latency: `csr_we` at cycle N gives `icap_we` at N+1. `csr_ready` is 0 at N+1 and back to its idle value from N+2.
- Reboot latency, `reboot_req` at cycle 0 with `icap_ready` held high:
  - `busy` is 1 from cycle 1.
  - `icap_we` pulses at cycles 1, 3, 5, … 19.
  - DONE is entered at cycle 21.
- A low `icap_ready` stretches ISSUE indefinitely. Words are never skipped or repeated.
- Asserting `sys_rst` mid-sequence aborts immediately. The next `reboot_req` restarts from idx 0.

## Configuration
- `SYSCTL_REBOOT_WATCHDOG_EN` defined:
  - A 32-bit counter clears on DONE entry and increments each cycle in DONE.
  - When it equals `watchdog_cycles - 1`, `fallback_reset` sets and stays 1 until `sys_rst`.
  - The counter saturates; it does not wrap.
- Not defined: the counter is absent and `fallback_reset` is tied to 0.

## Structure
- Shared package `sysctl_pkg`: the state enum, the 10-entry IPROG word constants, and the `IPROG_LEN = 10` constant.
- One sub-module, `sysctl_reboot_wdt`, holds the watchdog counter. It is instantiated only under the macro.

## Test plan
- Software write with `icap_ready = 1`: `csr_we` with `csr_d = 16'h1234`, `csr_ce = 0`, `csr_write = 1` -> one `icap_we` next cycle with `icap_d = 1234`, `icap_ce = 0`, `icap_write = 1`, and no `dropped`.
- Reboot with `reboot_addr = 24'h0A0000` and ready high -> 10 strobes on odd cycles 1..19 carrying FFFF, AA99, 5566, 3261, 0000, 3281, 0B0A, 30A1, 000E, 2000; `busy` = 1 from cycle 1.
- Ready stall: force `icap_ready` low for 5 cycles before word 4 -> `icap_we` delayed 5 cycles, and the word order is unchanged.
- Simultaneous `csr_we` and `reboot_req` in IDLE -> sequence starts, `dropped` pulses once, and no software word is issued. A later `csr_we` in DONE -> `dropped` again.
- Reset at word 6 -> outputs return to their reset values asynchronously. A new `reboot_req` restarts at FFFF.
- With the macro and `watchdog_cycles = 8`: sequence completes and the bench stays in DONE -> `fallback_reset` rises exactly 8 cycles after DONE entry and stays high.
